// File: rtl/id_pkg.sv
// Shared opcode, control-word and destination-select definitions for the ID stage.
// ctrl_t bit order: {RegDst, Jump, Branch, MemRead, MemtoReg, ALUop[1:0], MemWrite, ALUSrc, RegWrite}.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam int unsigned CTRL_REGDST   = 9;
    localparam int unsigned CTRL_JUMP     = 8;
    localparam int unsigned CTRL_BRANCH   = 7;
    localparam int unsigned CTRL_MEMREAD  = 6;
    localparam int unsigned CTRL_MEMTOREG = 5;
    localparam int unsigned CTRL_ALUOP1   = 4;
    localparam int unsigned CTRL_ALUOP0   = 3;
    localparam int unsigned CTRL_MEMWRITE = 2;
    localparam int unsigned CTRL_ALUSRC   = 1;
    localparam int unsigned CTRL_REGWRITE = 0;

    typedef logic [9:0] ctrl_t;

    localparam ctrl_t CTRL_RTYPE_C = 10'b1_0_0_0_0_10_0_0_1;
    localparam ctrl_t CTRL_LW_C    = 10'b0_0_0_1_1_00_0_1_1;
    localparam ctrl_t CTRL_SW_C    = 10'b0_0_0_0_0_00_1_1_0;
    localparam ctrl_t CTRL_BEQ_C   = 10'b0_0_1_0_0_01_0_0_0;
    localparam ctrl_t CTRL_ADDI_C  = 10'b0_0_0_0_0_00_0_1_1;
    localparam ctrl_t CTRL_J_C     = 10'b0_1_0_0_0_00_0_0_0;

    typedef enum logic [1:0] {
        WregNone,
        WregRt,
        WregRd
    } wreg_sel_e;

endpackage

// File: rtl/id_ctrl_decode.sv
// Combinational opcode decoder: control word, illegal flag, rt-usage and destination select.
module id_ctrl_decode
    import id_pkg::*;
(
    input  logic [5:0] opcode_i,
    output ctrl_t      ctrl_o,
    output logic       illegal_o,
    output logic       uses_rt_o,
    output wreg_sel_e  wreg_sel_o
);

    always_comb begin
        ctrl_o     = '0;
        illegal_o  = 1'b0;
        uses_rt_o  = 1'b0;
        wreg_sel_o = WregNone;
        case (opcode_i)
            OP_RTYPE: begin
                ctrl_o     = CTRL_RTYPE_C;
                uses_rt_o  = 1'b1;
                wreg_sel_o = WregRd;
            end
            OP_LW: begin
                ctrl_o     = CTRL_LW_C;
                wreg_sel_o = WregRt;
            end
            OP_SW: begin
                ctrl_o    = CTRL_SW_C;
                uses_rt_o = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o    = CTRL_BEQ_C;
                uses_rt_o = 1'b1;
            end
            OP_ADDI: begin
                ctrl_o     = CTRL_ADDI_C;
                wreg_sel_o = WregRt;
            end
            OP_J: begin
                ctrl_o = CTRL_J_C;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_decode_pipe.sv
// MIPS-style decode stage with a valid/ready ID/EX register, flush and illegal-opcode flag.
// Define ID_HAZARD_EN to enable load-use stall detection; otherwise hazard is tied low.
module id_decode_pipe
    import id_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    localparam int unsigned RW  = $clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [XLEN-1:0] if_pc_i,
    input  logic [31:0]     if_instr_i,
    input  logic            flush_i,
    output logic [RW-1:0]   rf_raddr1_o,
    output logic [RW-1:0]   rf_raddr2_o,
    input  logic [XLEN-1:0] rf_rdata1_i,
    input  logic [XLEN-1:0] rf_rdata2_i,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [XLEN-1:0] ex_rs_data_o,
    output logic [XLEN-1:0] ex_rt_data_o,
    output logic [XLEN-1:0] ex_imm_o,
    output logic [XLEN-1:0] ex_jtarget_o,
    output logic [RW-1:0]   ex_rs_o,
    output logic [RW-1:0]   ex_rt_o,
    output logic [RW-1:0]   ex_wreg_o,
    output logic [9:0]      ex_ctrl_o,
    output logic            ex_illegal_o
);

    logic [RW-1:0] rs, rt, rd;
    ctrl_t         dec_ctrl;
    logic          dec_illegal;
    logic          uses_rt;
    wreg_sel_e     wreg_sel;
    logic          hazard;
    logic          adv;
    logic          load;

    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_pc_q, ex_rs_data_q, ex_rt_data_q, ex_imm_q, ex_jtarget_q;
    logic [XLEN-1:0] ex_imm_d, ex_jtarget_d;
    logic [RW-1:0]   ex_rs_q, ex_rt_q, ex_wreg_q, ex_wreg_d;
    ctrl_t           ex_ctrl_q, ex_ctrl_d;
    logic            ex_illegal_q;

    assign rs = if_instr_i[21 +: RW];
    assign rt = if_instr_i[16 +: RW];
    assign rd = if_instr_i[11 +: RW];

    assign rf_raddr1_o = rs;
    assign rf_raddr2_o = rt;

    id_ctrl_decode u_ctrl_decode (
        .opcode_i   (if_instr_i[31:26]),
        .ctrl_o     (dec_ctrl),
        .illegal_o  (dec_illegal),
        .uses_rt_o  (uses_rt),
        .wreg_sel_o (wreg_sel)
    );

    always_comb begin
        ex_wreg_d = '0;
        case (wreg_sel)
            WregRd:  ex_wreg_d = rd;
            WregRt:  ex_wreg_d = rt;
            default: ex_wreg_d = '0;
        endcase
        // Writes to $0 are architecturally discarded; suppressing RegWrite keeps EX/WB simple.
        ex_ctrl_d                = dec_ctrl;
        ex_ctrl_d[CTRL_REGWRITE] = dec_ctrl[CTRL_REGWRITE] & (ex_wreg_d != '0);
        ex_imm_d                 = {{(XLEN-16){if_instr_i[15]}}, if_instr_i[15:0]};
        ex_jtarget_d             = {if_pc_i[XLEN-1:28], if_instr_i[25:0], 2'b00};
    end

`ifdef ID_HAZARD_EN
    assign hazard = ex_valid_q & ex_ctrl_q[CTRL_MEMREAD] & (ex_wreg_q != '0) &
                    ((ex_wreg_q == rs) | (uses_rt & (ex_wreg_q == rt)));
`else
    logic unused_uses_rt;
    assign unused_uses_rt = uses_rt;
    assign hazard         = 1'b0;
`endif

    assign adv        = ~ex_valid_q | ex_ready_i;
    assign if_ready_o = flush_i | (adv & ~hazard);
    assign load       = ~flush_i & adv & if_valid_i & ~hazard;

    always_comb begin
        ex_valid_d = ex_valid_q;
        if (flush_i) begin
            ex_valid_d = 1'b0;
        end else if (adv) begin
            ex_valid_d = if_valid_i & ~hazard;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            ex_jtarget_q <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_wreg_q    <= '0;
            ex_ctrl_q    <= '0;
            ex_illegal_q <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            if (load) begin
                ex_pc_q      <= if_pc_i;
                ex_rs_data_q <= rf_rdata1_i;
                ex_rt_data_q <= rf_rdata2_i;
                ex_imm_q     <= ex_imm_d;
                ex_jtarget_q <= ex_jtarget_d;
                ex_rs_q      <= rs;
                ex_rt_q      <= rt;
                ex_wreg_q    <= ex_wreg_d;
                ex_ctrl_q    <= ex_ctrl_d;
                ex_illegal_q <= dec_illegal;
            end
        end
    end

    assign ex_valid_o   = ex_valid_q;
    assign ex_pc_o      = ex_pc_q;
    assign ex_rs_data_o = ex_rs_data_q;
    assign ex_rt_data_o = ex_rt_data_q;
    assign ex_imm_o     = ex_imm_q;
    assign ex_jtarget_o = ex_jtarget_q;
    assign ex_rs_o      = ex_rs_q;
    assign ex_rt_o      = ex_rt_q;
    assign ex_wreg_o    = ex_wreg_q;
    assign ex_ctrl_o    = ex_ctrl_q;
    assign ex_illegal_o = ex_illegal_q;

endmodule

// File: tb/tb_id_decode_pipe.sv
// Directed-vector bench for id_decode_pipe; load-use expectations follow ID_HAZARD_EN.
module tb_id_decode_pipe;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_jtarget;
    logic [4:0]  ex_rs, ex_rt, ex_wreg;
    logic [9:0]  ex_ctrl;
    logic        ex_illegal;

    int vectors;
    int miscompares;

    // Register file model: register n reads as 0x1000 + n.
    assign rf_rdata1 = 32'h1000 | {27'h0, rf_raddr1};
    assign rf_rdata2 = 32'h1000 | {27'h0, rf_raddr2};

    id_decode_pipe #(
        .XLEN (32),
        .NREG (32)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .if_valid_i   (if_valid),
        .if_ready_o   (if_ready),
        .if_pc_i      (if_pc),
        .if_instr_i   (if_instr),
        .flush_i      (flush),
        .rf_raddr1_o  (rf_raddr1),
        .rf_raddr2_o  (rf_raddr2),
        .rf_rdata1_i  (rf_rdata1),
        .rf_rdata2_i  (rf_rdata2),
        .ex_valid_o   (ex_valid),
        .ex_ready_i   (ex_ready),
        .ex_pc_o      (ex_pc),
        .ex_rs_data_o (ex_rs_data),
        .ex_rt_data_o (ex_rt_data),
        .ex_imm_o     (ex_imm),
        .ex_jtarget_o (ex_jtarget),
        .ex_rs_o      (ex_rs),
        .ex_rt_o      (ex_rt),
        .ex_wreg_o    (ex_wreg),
        .ex_ctrl_o    (ex_ctrl),
        .ex_illegal_o (ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        if_valid = v;
        if_instr = instr;
        if_pc    = pc;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        drive(1'b1, 32'h0043_0820, 32'h0000_0104);
        tick();
        tick();
        vectors++;
        if (ex_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b expected 0", ex_valid);
        end
        vectors++;
        if (ex_ctrl !== 10'h000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %h expected 000", ex_ctrl);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (ex_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL add_valid: got %b expected 1", ex_valid);
        end
        vectors++;
        if (ex_ctrl !== 10'h211) begin
            miscompares++;
            $display("FAIL add_ctrl: got %h expected 211", ex_ctrl);
        end
        vectors++;
        if (ex_wreg !== 5'd1) begin
            miscompares++;
            $display("FAIL add_wreg: got %0d expected 1", ex_wreg);
        end
        vectors++;
        if (ex_rs_data !== 32'h1002 || ex_rt_data !== 32'h1003) begin
            miscompares++;
            $display("FAIL add_operands: got %h/%h expected 00001002/00001003",
                     ex_rs_data, ex_rt_data);
        end
        vectors++;
        if (ex_pc !== 32'h0000_0104) begin
            miscompares++;
            $display("FAIL add_pc: got %h expected 00000104", ex_pc);
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_immediates();
        drive(1'b1, 32'h8CC5_FFFC, 32'h0000_0200);
        tick();
        vectors++;
        if (ex_imm !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL lw_imm: got %h expected fffffffc", ex_imm);
        end
        vectors++;
        if (ex_ctrl !== 10'h063 || ex_wreg !== 5'd5) begin
            miscompares++;
            $display("FAIL lw_ctrl_wreg: got %h/%0d expected 063/5", ex_ctrl, ex_wreg);
        end
        drive(1'b1, 32'h0800_0100, 32'h4000_0004);
        tick();
        vectors++;
        if (ex_jtarget !== 32'h4000_0400) begin
            miscompares++;
            $display("FAIL j_target: got %h expected 40000400", ex_jtarget);
        end
        vectors++;
        if (ex_ctrl !== 10'h100 || ex_wreg !== 5'd0) begin
            miscompares++;
            $display("FAIL j_ctrl_wreg: got %h/%0d expected 100/0", ex_ctrl, ex_wreg);
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        vectors++;
        if (ex_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_bubble: got %b expected 0", ex_valid);
        end
    endtask

    task automatic test_load_use();
        drive(1'b1, 32'h8CC5_FFFC, 32'h0000_0300);
        tick();
        drive(1'b1, 32'h00A1_3820, 32'h0000_0304);
        #1;
`ifdef ID_HAZARD_EN
        vectors++;
        if (if_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL loaduse_stall: got if_ready %b expected 0", if_ready);
        end
        tick();
        vectors++;
        if (ex_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL loaduse_bubble: got ex_valid %b expected 0", ex_valid);
        end
        vectors++;
        if (if_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL loaduse_release: got if_ready %b expected 1", if_ready);
        end
`else
        vectors++;
        if (if_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL nohazard_ready: got if_ready %b expected 1", if_ready);
        end
`endif
        tick();
        vectors++;
        if (ex_valid !== 1'b1 || ex_wreg !== 5'd7 || ex_rs !== 5'd5 || ex_rt !== 5'd1) begin
            miscompares++;
            $display("FAIL loaduse_capture: got v=%b wreg=%0d rs=%0d rt=%0d expected 1/7/5/1",
                     ex_valid, ex_wreg, ex_rs, ex_rt);
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_backpressure();
        ex_ready = 1'b1;
        drive(1'b1, 32'hAC43_0008, 32'h0000_0400);
        tick();
        ex_ready = 1'b0;
        drive(1'b1, 32'h1022_0010, 32'h0000_0404);
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (if_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_ready[%0d]: got %b expected 0", i, if_ready);
            end
            tick();
            vectors++;
            if (ex_valid !== 1'b1 || ex_ctrl !== 10'h006 || ex_imm !== 32'h8 ||
                ex_pc !== 32'h0000_0400) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got v=%b ctrl=%h imm=%h pc=%h expected 1/006/8/400",
                         i, ex_valid, ex_ctrl, ex_imm, ex_pc);
            end
        end
        ex_ready = 1'b1;
        #1;
        vectors++;
        if (if_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_resume_ready: got %b expected 1", if_ready);
        end
        tick();
        vectors++;
        if (ex_valid !== 1'b1 || ex_ctrl !== 10'h088 || ex_imm !== 32'h10 ||
            ex_rs !== 5'd1 || ex_rt !== 5'd2) begin
            miscompares++;
            $display("FAIL bp_beq: got v=%b ctrl=%h imm=%h rs=%0d rt=%0d expected 1/088/10/1/2",
                     ex_valid, ex_ctrl, ex_imm, ex_rs, ex_rt);
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        vectors++;
        if (ex_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_no_dup: got %b expected 0", ex_valid);
        end
    endtask

    task automatic test_flush();
        ex_ready = 1'b1;
        drive(1'b1, 32'h0043_0820, 32'h0000_0500);
        tick();
        ex_ready = 1'b0;
        flush    = 1'b1;
        drive(1'b1, 32'h8CC5_FFFC, 32'h0000_0504);
        #1;
        vectors++;
        if (if_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_ready: got %b expected 1", if_ready);
        end
        tick();
        vectors++;
        if (ex_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_kill: got %b expected 0", ex_valid);
        end
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        vectors++;
        if (ex_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_consumed: got %b expected 0", ex_valid);
        end
        ex_ready = 1'b1;
    endtask

    task automatic test_edge_cases();
        drive(1'b1, 32'hFC00_0000, 32'h0000_0600);
        tick();
        vectors++;
        if (ex_illegal !== 1'b1 || ex_ctrl !== 10'h000 || ex_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_op: got ill=%b ctrl=%h v=%b expected 1/000/1",
                     ex_illegal, ex_ctrl, ex_valid);
        end
        drive(1'b1, 32'h2020_0005, 32'h0000_0604);
        tick();
        vectors++;
        if (ex_ctrl !== 10'h002 || ex_wreg !== 5'd0 || ex_illegal !== 1'b0 ||
            ex_imm !== 32'h5) begin
            miscompares++;
            $display("FAIL addi_r0: got ctrl=%h wreg=%0d ill=%b imm=%h expected 002/0/0/5",
                     ex_ctrl, ex_wreg, ex_illegal, ex_imm);
        end
        drive(1'b1, 32'h8C20_0000, 32'h0000_0608);
        tick();
        vectors++;
        if (ex_ctrl !== 10'h062 || ex_wreg !== 5'd0) begin
            miscompares++;
            $display("FAIL lw_r0: got ctrl=%h wreg=%0d expected 062/0", ex_ctrl, ex_wreg);
        end
        drive(1'b1, 32'h0000_1020, 32'h0000_060C);
        #1;
        vectors++;
        if (if_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL r0_no_stall: got if_ready %b expected 1", if_ready);
        end
        tick();
        vectors++;
        if (ex_valid !== 1'b1 || ex_wreg !== 5'd2 || ex_ctrl !== 10'h211) begin
            miscompares++;
            $display("FAIL r0_use: got v=%b wreg=%0d ctrl=%h expected 1/2/211",
                     ex_valid, ex_wreg, ex_ctrl);
        end
        // Asynchronous reset mid-cycle must clear the stage without waiting for an edge.
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 10'h000 || ex_wreg !== 5'd0) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b ctrl=%h wreg=%0d expected 0/000/0",
                     ex_valid, ex_ctrl, ex_wreg);
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_immediates();
        test_load_use();
        test_backpressure();
        test_flush();
        test_edge_cases();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
